// File: rtl/flash_fetch_unit.sv
// Instruction prefetch between a multi-cycle FLASH (req/ack) and the processor fetch port.
// Optional FETCH_STATS_EN adds saturating HIT_CNT / MISS_CNT outputs.
module flash_fetch_unit #(
  parameter int                      DATA_BUS_LEN = 32,
  parameter int                      DEPTH        = 4,
  parameter logic [DATA_BUS_LEN-1:0] RESET_ADDR   = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_BUS_LEN-1:0] PC_ADDR_IN,
  input  logic                    IF_TAKE,
  output logic [DATA_BUS_LEN-1:0] INSTR_OUT,
  output logic                    INSTR_VALID,
  output logic                    FLASH_REQ,
  output logic [DATA_BUS_LEN-1:0] FLASH_ADDR,
  input  logic                    FLASH_ACK,
  input  logic [DATA_BUS_LEN-1:0] FLASH_RDATA
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]             HIT_CNT,
  output logic [31:0]             MISS_CNT
`endif
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t                  state, state_nxt;
  logic [DATA_BUS_LEN-1:0] tag_q   [DEPTH];
  logic [DATA_BUS_LEN-1:0] instr_q [DEPTH];
  logic [PTR_W-1:0]        head, tail;
  logic [CNT_W-1:0]        count, count_pop;
  logic [DATA_BUS_LEN-1:0] fetch_ptr, fetch_nxt;
  logic [DATA_BUS_LEN-1:0] redir_ptr, redir_nxt;
  logic [DATA_BUS_LEN-1:0] exp_addr;
  logic                    not_empty, instr_valid, redirect, pop, push, flush;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign not_empty   = (count != '0);
  assign exp_addr    = not_empty ? tag_q[head] : fetch_ptr;
  assign instr_valid = not_empty && (tag_q[head] == PC_ADDR_IN);
  // While draining an abandoned request the queue is empty; the pending target lives in redir_ptr.
  assign redirect    = (state == DROP) ? (PC_ADDR_IN != redir_ptr) : (PC_ADDR_IN != exp_addr);
  assign pop         = instr_valid && IF_TAKE;
  assign count_pop   = count - CNT_W'(pop);

  assign INSTR_VALID = instr_valid;
  assign INSTR_OUT   = instr_valid ? instr_q[head] : '0;
  assign FLASH_REQ   = (state != IDLE);
  assign FLASH_ADDR  = fetch_ptr;

  always_comb begin
    state_nxt = state;
    fetch_nxt = fetch_ptr;
    redir_nxt = redir_ptr;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          flush     = 1'b1;
          fetch_nxt = PC_ADDR_IN;
        end else if (count_pop < FULL) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (FLASH_ACK) begin
          if (redirect) begin
            flush     = 1'b1;
            fetch_nxt = PC_ADDR_IN;
            state_nxt = IDLE;
          end else begin
            push      = 1'b1;
            fetch_nxt = fetch_ptr + 1'b1;
            if ((count_pop + 1'b1) >= FULL) state_nxt = IDLE;
          end
        end else if (redirect) begin
          // The outstanding request cannot be withdrawn; remember the target and drain it.
          flush     = 1'b1;
          redir_nxt = PC_ADDR_IN;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (FLASH_ACK) begin
          fetch_nxt = redir_ptr;
          state_nxt = IDLE;
        end else if (redirect) begin
          redir_nxt = PC_ADDR_IN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fetch_ptr <= RESET_ADDR;
      redir_ptr <= RESET_ADDR;
    end else begin
      state     <= state_nxt;
      fetch_ptr <= fetch_nxt;
      redir_ptr <= redir_nxt;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      tag_q[tail]   <= fetch_ptr;
      instr_q[tail] <= FLASH_RDATA;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else begin
      if (pop)      HIT_CNT  <= sat_inc(HIT_CNT);
      if (redirect) MISS_CNT <= sat_inc(MISS_CNT);
    end
  end
`endif

endmodule
